ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit; sits directly upstream of the if_id register, which feeds the decode stage.
- Owns the PC and issues in-order requests on the instruction bus.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle to if_id.
- Honours the decode load-use stall and the execute-stage jump redirect, and discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, FIFO entries; also the bound on in-flight requests (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- stall_i  in  1  hold the output entry (decode load-use stall).
- jump_flag_i  in  1  redirect request from execute.
- jump_addr_i  in  32  redirect target.
- ibus_req_o  out  1  fetch request valid.
- ibus_addr_o  out  32  fetch address.
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  response data valid; responses arrive in order, ≥1 cycle after gnt.
- ibus_rdata_i  in  32  response instruction.
- inst_valid_o  out  1  inst_o/inst_addr_o carry a real instruction.
- inst_o  out  32  instruction to if_id.
- inst_addr_o  out  32  address of inst_o.

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - ibus_req_o = 0.
  - inst_valid_o = 0, inst_o = NOP (32'h0000_0013), inst_addr_o = 0.
- Reset mid-operation:
  - Clears all state.
  - Responses for requests granted before reset are ignored: drop_cnt stays 0, and a bus reset is required.
- Request issue:
  - ibus_req_o = !rst_i && !jump_flag_i && (outstanding + drop_cnt + count < DEPTH).
  - ibus_addr_o = fetch_pc.
  - Request held stable until gnt.
- Grant (req && gnt): fetch_pc += 4 (wraps modulo 2^32); push fetch_pc into the in-flight address queue; outstanding++.
- Response:
  - If drop_cnt > 0: discard the response; drop_cnt--.
  - Otherwise: pop the address queue, push {addr, rdata} into the FIFO, outstanding--.
  - The credit rule guarantees the FIFO never overflows.
- Output:
  - inst_valid_o = (count != 0).
  - inst_o / inst_addr_o = FIFO head; NOP/0 when empty.
  - Head pops when inst_valid_o && !stall_i.
- Bypass: none. Response-to-output latency is 1 cycle (written into the FIFO, visible next cycle).
- Stall: head held; requests continue until credits are exhausted.
- Redirect (jump_flag_i = 1):
  - Takes priority over stall, grant and response.
  - Next cycle:
    - fetch_pc = {jump_addr_i[31:2], 2'b00}.
    - FIFO count = 0.
    - Address queue cleared.
    - drop_cnt = drop_cnt + outstanding − (rvalid this cycle ? 1 : 0).
    - outstanding = 0.
  - No pop occurs in the jump cycle.
  - ibus_req_o = 0 in the jump cycle. Requests resume the following cycle at the target.
- Back-to-back jumps: each updates fetch_pc; drop_cnt accumulates correctly.
- Simultaneous response and pop on a full FIFO: both occur; count unchanged.
- Simultaneous gnt and rvalid: outstanding unchanged.
- Counters are sized for values up to DEPTH. outstanding + drop_cnt + count ≤ DEPTH must hold at all times; an assertion is provided.

Test Plan:
- Reset, zero-wait memory (gnt = 1 combinationally, rvalid next cycle), stall = 0 → req at 0x0, 0x4, 0x8…; inst_valid_o rises on cycle 3 after reset release; one instruction per cycle with matching addresses.
- stall_i = 1 for 4 cycles with 2 instructions buffered → inst_o/inst_addr_o constant; ibus_req_o = 0 once credits are exhausted; on release, 0x8, 0xC emitted in order with no loss or duplication.
- Two requests outstanding (0x10, 0x14), jump_flag_i = 1 with jump_addr_i = 0x203 → next request at 0x200; the two stale responses are dropped (inst_valid_o never shows 0x10/0x14); first valid output is addr 0x200.
- Jump in the same cycle as rvalid of the sole outstanding request → drop_cnt = 0; that response is not emitted; fetch restarts at the target.
- Random gnt/rvalid delays (0–5 cycles) with random stalls and jumps, 10k cycles → output address stream matches a reference PC model; credit assertion never fires.
- rst_i asserted while stalled with a full FIFO → next cycle inst_valid_o = 0, inst_o = 32'h0000_0013; first request after release at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order bus requests,
// buffers responses and hands one instruction per cycle to if_id.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] frd_q, fwr_q;
  logic [PW-1:0] qrd_q, qwr_q;
  logic [31:0]   fa_q [DEPTH];
  logic [31:0]   fd_q [DEPTH];
  logic [31:0]   qa_q [DEPTH];

  logic [SW-1:0] credit;
  logic          gnt_fire;
  logic          rsp_drop;
  logic          rsp_take;
  logic          rsp_any;
  logic          pop;
  logic          unused_jaddr;

  assign unused_jaddr = ^jump_addr_i[1:0];

  assign credit = SW'(out_q) + SW'(drop_q) + SW'(cnt_q);

  assign ibus_req_o  = !rst_i && !jump_flag_i
                     && (credit < SW'(DEPTH));
  assign ibus_addr_o = pc_q;

  assign gnt_fire = ibus_req_o && ibus_gnt_i;
  // responses with nothing in flight are stray and ignored
  assign rsp_any  = ibus_rvalid_i
                  && ((drop_q != '0) || (out_q != '0));
  assign rsp_drop = ibus_rvalid_i && (drop_q != '0);
  assign rsp_take = rsp_any && (drop_q == '0)
                  && !jump_flag_i;

  assign inst_valid_o = (cnt_q != '0);
  assign pop = inst_valid_o && !stall_i && !jump_flag_i;

  assign inst_o      = inst_valid_o ? fd_q[frd_q] : NOP;
  assign inst_addr_o = inst_valid_o ? fa_q[frd_q] : 32'h0;

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (jump_flag_i) begin
      pc_d   = {jump_addr_i[31:2], 2'b00};
      cnt_d  = '0;
      out_d  = '0;
      drop_d = drop_q + out_q - CW'(rsp_any);
    end else begin
      if (gnt_fire) begin
        pc_d = pc_q + 32'd4;
      end
      out_d  = out_q + CW'(gnt_fire) - CW'(rsp_take);
      drop_d = drop_q - CW'(rsp_drop);
      cnt_d  = cnt_q + CW'(rsp_take) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      out_q  <= '0;
      drop_q <= '0;
      frd_q  <= '0;
      fwr_q  <= '0;
      qrd_q  <= '0;
      qwr_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      if (jump_flag_i) begin
        frd_q <= '0;
        fwr_q <= '0;
        qrd_q <= '0;
        qwr_q <= '0;
      end else begin
        if (gnt_fire) qwr_q <= qwr_q + 1'b1;
        if (rsp_take) begin
          qrd_q <= qrd_q + 1'b1;
          fwr_q <= fwr_q + 1'b1;
        end
        if (pop) frd_q <= frd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !jump_flag_i) begin
      if (gnt_fire) qa_q[qwr_q] <= pc_q;
      if (rsp_take) begin
        fa_q[fwr_q] <= qa_q[qrd_q];
        fd_q[fwr_q] <= ibus_rdata_i;
      end
    end
  end

  credit_ok: assert property (
    @(posedge clk_i) disable iff (rst_i)
    credit <= SW'(DEPTH)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch against an epoch-tagged
// transaction model of the bus and the if_id output stream.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [31:0] jaddr;
  logic        req;
  logic [31:0] baddr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] iaddr;

  ifu_fetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .jump_flag_i  (jump),
    .jump_addr_i  (jaddr),
    .ibus_req_o   (req),
    .ibus_addr_o  (baddr),
    .ibus_gnt_i   (gnt),
    .ibus_rvalid_i(rvalid),
    .ibus_rdata_i (rdata),
    .inst_valid_o (valid),
    .inst_o       (inst),
    .inst_addr_o  (iaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          rdy;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  pend_t       pend[$];
  ent_t        fifo[$];
  logic [31:0] exp_pc;
  int          ep;
  int          cyc;
  int          errs;
  int          checks;

  int          p_stall;
  int          p_jump;
  int          p_rst;
  int          p_gnt;
  int          max_lat;
  bit          use_fix;
  logic [31:0] ja_fix;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %h expected %h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [31:0] ja;
    pend_t       e;
    ent_t        n;
    @(negedge clk);
    cyc++;
    rst   = ($urandom_range(999) < p_rst);
    stall = ($urandom_range(99) < p_stall);
    jump  = !rst && ($urandom_range(99) < p_jump);
    ja    = use_fix ? ja_fix : ($urandom & 32'h0000_3fff);
    jaddr = ja;
    gnt   = ($urandom_range(99) < p_gnt);
    rvalid = !rst && (pend.size() != 0)
           && (pend[0].rdy <= cyc);
    rdata = rvalid ? mem(pend[0].addr) : $urandom;
    #1;
    chk("req", 32'(req),
        32'(!rst && !jump
            && (pend.size() + fifo.size() < DEPTH)));
    chk("valid", 32'(valid), 32'(fifo.size() != 0));
    chk("inst", inst,
        (fifo.size() != 0) ? fifo[0].data : NOP);
    chk("iaddr", iaddr,
        (fifo.size() != 0) ? fifo[0].addr : 32'h0);
    if (req) chk("baddr", baddr, exp_pc);
    @(posedge clk);
    if (rst) begin
      pend.delete();
      fifo.delete();
      ep++;
      exp_pc = RESET_PC;
      return;
    end
    if (rvalid) e = pend.pop_front();
    if (!jump && !stall && fifo.size() != 0)
      void'(fifo.pop_front());
    if (rvalid && !jump && e.ep == ep) begin
      n.addr = e.addr;
      n.data = mem(e.addr);
      fifo.push_back(n);
    end
    if (req && gnt) begin
      e.addr = exp_pc;
      e.ep   = ep;
      e.rdy  = cyc + $urandom_range(max_lat, 1);
      pend.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (jump) begin
      ep++;
      fifo.delete();
      exp_pc = {ja[31:2], 2'b00};
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0; ep = 0;
    exp_pc = RESET_PC;
    use_fix = 1'b0; ja_fix = '0;
    rst = 1'b1; stall = 1'b0; jump = 1'b0;
    jaddr = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);

    // reset state observed while reset is held
    p_rst = 1000; p_stall = 0; p_jump = 0;
    p_gnt = 100;  max_lat = 1;
    run(2);

    // zero-wait memory, free-flowing decode
    p_rst = 0;
    run(12);

    // stall with buffered instructions, then release
    p_stall = 100;
    run(6);
    p_stall = 0;
    run(6);

    // slower memory, then redirect to an unaligned target
    max_lat = 3;
    run(5);
    use_fix = 1'b1; ja_fix = 32'h0000_0203; p_jump = 100;
    run(1);
    use_fix = 1'b0; p_jump = 0;
    run(10);

    // fill the FIFO under stall, reset mid-operation
    max_lat = 1;
    p_stall = 100;
    run(8);
    p_rst = 1000;
    run(1);
    p_rst = 0; p_stall = 0;
    run(6);

    // long random run
    p_gnt = 60; max_lat = 6;
    p_stall = 25; p_jump = 3; p_rst = 1;
    run(10000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
